// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU control path: sequencer states, saturation value.
// MAX also sets the default datapath width of the ALU and the sequencer.
package alu_ctrl_pkg;

  localparam logic [7:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU; add clips at all-ones, sub clips at zero.
// Ports: a, b operands; cmd command code; result n-bit output.
`include "alucodes.sv"

module alu
  import alu_ctrl_pkg::*;
#(
  parameter int n = $bits(MAX)
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [2:0]   cmd,
  output logic [n-1:0] result
);

  logic [n:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    case (cmd)
      `RADD: result = sum[n] ? {n{1'b1}} : sum[n-1:0];
      `RSUB: result = (a > b) ? a - b : '0;
      `RAND: result = a & b;
      `ROR:  result = a | b;
      `RXOR: result = a ^ b;
      `RSHL: result = a << 1;
      `RSHR: result = a >> 1;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alucodes.sv
// ALU command encodings shared by the ALU, its sequencer and benches.
// Pure macro file; guarded so several includers can share it.
`ifndef ALUCODES_SV
`define ALUCODES_SV
`define NOP  3'd0
`define RADD 3'd1
`define RSUB 3'd2
`define RAND 3'd3
`define ROR  3'd4
`define RXOR 3'd5
`define RSHL 3'd6
`define RSHR 3'd7
`endif

// File: rtl/alu_mul_sequencer.sv
// Muxes ALU ports between decoder and a saturating multiply-by-repeated-add
// sequencer. Ports: clock, n_reset; start, core_a/b/cmd from decoder;
// alu_result in; alu_a/b/cmd out; ready, busy, done, product status.
`include "alucodes.sv"

module alu_mul_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int n = $bits(MAX)
) (
  input  logic         clock,
  input  logic         n_reset,
  input  logic         start,
  input  logic [n-1:0] core_a,
  input  logic [n-1:0] core_b,
  input  logic [2:0]   core_cmd,
  input  logic [n-1:0] alu_result,
  output logic [n-1:0] alu_a,
  output logic [n-1:0] alu_b,
  output logic [2:0]   alu_cmd,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] product
);

  localparam logic [n-1:0] SAT = {n{1'b1}};
  localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

  mul_state_t   state;
  mul_state_t   state_next;
  logic [n-1:0] acc;
  logic [n-1:0] mcand;
  logic [n-1:0] count;

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

  // ALU mux kept apart from next-state so the ALU
  // feedback path is not a false combinational loop.
  always_comb begin
    alu_a   = core_a;
    alu_b   = core_b;
    alu_cmd = core_cmd;
    unique case (state)
      ADD: begin
        alu_a   = acc;
        alu_b   = mcand;
        alu_cmd = `RADD;
      end
      DONE: begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cmd = `NOP;
      end
      default: ;
    endcase
  end

  // Exit on count==1 before the decrement would
  // reach zero; all-ones is sticky so stop early.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (core_a == '0 || core_b == '0)
            state_next = DONE;
          else
            state_next = ADD;
        end
      end
      ADD: begin
        if (count == ONE || alu_result == SAT)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state_next == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= core_a;
            count <= core_b;
            acc   <= '0;
          end
        end
        ADD: begin
          acc   <= alu_result;
          count <= count - ONE;
        end
        default: ;
      endcase
      // Load on the entry edge so product is valid
      // alongside done; a zero operand yields 0.
      if (state_next == DONE)
        product <= (state == ADD) ? alu_result : '0;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer paired with the shared ALU.
// Cycle c is the interval following edge c-1; start is sampled at edge 0.
`ifndef ALUCODES_SV
`include "alucodes.sv"
`endif

module tb_alu_mul_sequencer;

  logic       clock;
  logic       n_reset;
  logic       start;
  logic [7:0] core_a;
  logic [7:0] core_b;
  logic [2:0] core_cmd;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_cmd;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int nvec;
  int nerr;

  alu_mul_sequencer #(.n(8)) dut (
    .clock      (clock),
    .n_reset    (n_reset),
    .start      (start),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_cmd   (core_cmd),
    .alu_result (alu_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cmd    (alu_cmd),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  alu #(.n(8)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .cmd    (alu_cmd),
    .result (alu_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [7:0] a,
                        input logic [7:0] b);
    core_a   = a;
    core_b   = b;
    core_cmd = `NOP;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    nvec     = 0;
    nerr     = 0;
    n_reset  = 1'b0;
    start    = 1'b0;
    core_a   = '0;
    core_b   = '0;
    core_cmd = `NOP;
    #2;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_product", 32'(product), 0);
    tick();
    tick();
    n_reset = 1'b1;
    tick();

    // IDLE pass-through
    core_a   = 8'd9;
    core_b   = 8'd4;
    core_cmd = `RSUB;
    #1;
    chk("pt_a", 32'(alu_a), 9);
    chk("pt_b", 32'(alu_b), 4);
    chk("pt_cmd", 32'(alu_cmd), 32'(`RSUB));
    chk("pt_result", 32'(alu_result), 5);
    tick();

    // 3*5 with core_* toggling while busy
    launch(8'd3, 8'd5);
    for (int c = 1; c <= 6; c++) begin
      core_a   = 8'(c * 17);
      core_b   = 8'(c * 3);
      core_cmd = `RXOR;
      #1;
      chk("m35_busy", 32'(busy), 1);
      chk("m35_done", 32'(done), (c == 6) ? 1 : 0);
      if (c <= 5) begin
        chk("m35_cmd", 32'(alu_cmd), 32'(`RADD));
        chk("m35_a", 32'(alu_a), 32'((c - 1) * 3));
        chk("m35_b", 32'(alu_b), 3);
        tick();
      end
    end
    chk("m35_product", 32'(product), 15);
    chk("m35_dcmd", 32'(alu_cmd), 32'(`NOP));
    tick();
    chk("m35_ready", 32'(ready), 1);
    chk("m35_done_off", 32'(done), 0);

    // 0*200: pass-through in start cycle, then straight to DONE
    core_a   = 8'd0;
    core_b   = 8'd200;
    core_cmd = `RAND;
    start    = 1'b1;
    #1;
    chk("z0_startcmd", 32'(alu_cmd), 32'(`RAND));
    tick();
    start = 1'b0;
    chk("z0_done", 32'(done), 1);
    chk("z0_product", 32'(product), 0);
    chk("z0_cmd", 32'(alu_cmd), 32'(`NOP));
    tick();
    chk("z0_ready", 32'(ready), 1);

    // 7*0
    launch(8'd7, 8'd0);
    chk("z1_done", 32'(done), 1);
    chk("z1_product", 32'(product), 0);
    chk("z1_cmd", 32'(alu_cmd), 32'(`NOP));
    tick();

    // 20*20 clips at add 13
    launch(8'd20, 8'd20);
    for (int c = 1; c <= 13; c++) begin
      chk("m20_done", 32'(done), 0);
      chk("m20_busy", 32'(busy), 1);
      tick();
    end
    chk("m20_done14", 32'(done), 1);
    chk("m20_product", 32'(product), 255);
    tick();

    // 255*255 clips on first add
    launch(8'd255, 8'd255);
    chk("mff_done1", 32'(done), 0);
    chk("mff_sum", 32'(alu_result), 255);
    tick();
    chk("mff_done2", 32'(done), 1);
    chk("mff_product", 32'(product), 255);
    tick();

    // 2*6 with a rejected start in cycle 3
    launch(8'd2, 8'd6);
    tick();
    tick();
    core_a = 8'd9;
    core_b = 8'd9;
    start  = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_busy", 32'(busy), 1);
    chk("rej_a", 32'(alu_a), 6);
    tick();
    tick();
    tick();
    chk("rej_done7", 32'(done), 1);
    chk("rej_product", 32'(product), 12);
    for (int c = 8; c <= 12; c++) begin
      tick();
      chk("rej_nodone", 32'(done), 0);
      chk("rej_idle", 32'(ready), 1);
    end
    chk("rej_hold", 32'(product), 12);

    // 10*10 aborted by reset in cycle 4
    launch(8'd10, 8'd10);
    tick();
    tick();
    tick();
    chk("rm_busy_pre", 32'(busy), 1);
    #3;
    n_reset = 1'b0;
    #1;
    chk("rm_ready", 32'(ready), 1);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_product", 32'(product), 0);
    chk("rm_done", 32'(done), 0);
    #2;
    n_reset = 1'b1;
    tick();
    chk("rm_nodone", 32'(done), 0);

    // 1*1 after release
    launch(8'd1, 8'd1);
    chk("m11_done1", 32'(done), 0);
    chk("m11_busy", 32'(busy), 1);
    tick();
    chk("m11_done2", 32'(done), 1);
    chk("m11_product", 32'(product), 1);
    tick();
    chk("m11_ready", 32'(ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
